// File: rtl/onchip_mem_tester_pkg.sv
// Shared types and helpers for the on-chip memory tester: FSM states,
// the test pattern and the saturation limit of the error counter.
package onchip_mem_tester_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_DRAIN,
    S_DONE
  } state_e;

  localparam logic [15:0] ERR_MAX = 16'hFFFF;

  // Word i of a run holds seed + i; the adder wraps modulo 2^32.
  function automatic logic [31:0] pattern_word(input logic [31:0] seed,
                                               input logic [31:0] idx);
    return seed + idx;
  endfunction

endpackage

// File: rtl/onchip_mem_tester_chk.sv
// Read-back checker: walks the expected pattern in step with the in-order
// read responses and records the mismatch count and first failing address.
module onchip_mem_tester_chk
  import onchip_mem_tester_pkg::*;
#(
  parameter int ADDR_W = 13,
  parameter int CNT_W  = 12
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clear,
  input  logic [31:0]         seed,
  input  logic [ADDR_W-3:0]   base,
  input  logic                rsp_valid,
  input  logic [31:0]         rsp_data,
  output logic [15:0]         err_count,
  output logic [ADDR_W-1:0]   first_fail_addr
);

  localparam int WORD_W = ADDR_W - 2;

  logic [CNT_W-1:0]  rx_q, rx_d;
  logic [15:0]       err_q, err_d;
  logic [ADDR_W-1:0] ffa_q, ffa_d;
  logic [31:0]       exp_word;
  logic [WORD_W-1:0] rx_word;

  // NOTE: every variable gets a default at the top of always_comb so that no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    rx_d     = rx_q;
    err_d    = err_q;
    ffa_d    = ffa_q;
    exp_word = pattern_word(seed, 32'(rx_q));
    rx_word  = base + rx_q[WORD_W-1:0];
    if (clear) begin
      rx_d  = '0;
      err_d = '0;
      ffa_d = '0;
    end else if (rsp_valid) begin
      rx_d = rx_q + CNT_W'(1);
      if (rsp_data != exp_word) begin
        if (err_q != ERR_MAX) err_d = err_q + 16'd1;
        // A zero count means no mismatch yet this run, so this one is the first.
        if (err_q == '0) ffa_d = {rx_word, 2'b00};
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_q  <= '0;
      err_q <= '0;
      ffa_q <= '0;
    end else begin
      rx_q  <= rx_d;
      err_q <= err_d;
      ffa_q <= ffa_d;
    end
  end

  assign err_count       = err_q;
  assign first_fail_addr = ffa_q;

endmodule

// File: rtl/onchip_mem_tester.sv
// Avalon-MM memory self-test master: writes seed+i over a word range, reads it
// back with up to MAX_PEND outstanding reads and counts mismatches.
module onchip_mem_tester
  import onchip_mem_tester_pkg::*;
#(
  parameter int ADDR_W   = 13,
  parameter int CNT_W    = 12,
  parameter int MAX_PEND = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-3:0] base,
  input  logic [CNT_W-1:0]  count,
  input  logic [31:0]       seed,
  output logic              busy,
  output logic              done,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_fail_addr,
  output logic [ADDR_W-1:0] avm_address,
  output logic [3:0]        avm_byteenable,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid
);

  localparam int WORD_W = ADDR_W - 2;
  localparam int PEND_W = $clog2(MAX_PEND + 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] base_q, base_d;
  logic [31:0]       seed_q, seed_d;
  logic [PEND_W-1:0] pend_q, pend_d;

  logic              wr_acc, rd_acc, rsp_valid, last_idx, start_acc;
  logic [WORD_W-1:0] issue_word;

  // Bus outputs decode from state and the issue index only; both freeze while
  // stalled, which keeps address/data/command stable under waitrequest.
  always_comb begin
    issue_word     = base_q + idx_q[WORD_W-1:0];
    avm_write      = (state_q == S_WR);
    avm_read       = (state_q == S_RD) && (pend_q < PEND_W'(MAX_PEND));
    avm_address    = (avm_write || avm_read) ? {issue_word, 2'b00} : '0;
    avm_byteenable = (avm_write || avm_read) ? 4'hF : 4'h0;
    avm_writedata  = avm_write ? pattern_word(seed_q, 32'(idx_q)) : '0;
  end

  assign busy      = (state_q == S_WR) || (state_q == S_RD) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);
  assign wr_acc    = avm_write && !avm_waitrequest;
  assign rd_acc    = avm_read && !avm_waitrequest;
  assign rsp_valid = avm_readdatavalid && (pend_q != '0);
  assign last_idx  = (idx_q == cnt_q - CNT_W'(1));
  assign start_acc = start && (state_q == S_IDLE);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    seed_d  = seed_q;
    case ({rd_acc, rsp_valid})
      2'b10:   pend_d = pend_q + PEND_W'(1);
      2'b01:   pend_d = pend_q - PEND_W'(1);
      default: pend_d = pend_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d   = count;
          base_d  = base;
          seed_d  = seed;
          idx_d   = '0;
          state_d = (count != '0) ? S_WR : S_DONE;
        end
      end
      S_WR: begin
        if (wr_acc) begin
          if (last_idx) begin
            idx_d   = '0;
            state_d = S_RD;
          end else begin
            idx_d = idx_q + CNT_W'(1);
          end
        end
      end
      S_RD: begin
        if (rd_acc) begin
          idx_d = idx_q + CNT_W'(1);
          if (last_idx) state_d = S_DRAIN;
        end
      end
      // Looking at the next pending value lets done follow the last response directly.
      S_DRAIN: if (pend_d == '0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      base_q  <= '0;
      seed_q  <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      seed_q  <= seed_d;
      pend_q  <= pend_d;
    end
  end

  onchip_mem_tester_chk #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_chk (
    .clk             (clk),
    .reset_n         (reset_n),
    .clear           (start_acc),
    .seed            (seed_q),
    .base            (base_q),
    .rsp_valid       (rsp_valid),
    .rsp_data        (avm_readdata),
    .err_count       (err_count),
    .first_fail_addr (first_fail_addr)
  );

endmodule

// File: tb/tb_onchip_mem_tester.sv
// Scoreboard bench for onchip_mem_tester: stimulus pushes expected bus
// transfers and run results, a monitor pops and compares as the DUT presents them.
module tb_onchip_mem_tester;

  localparam int ADDR_W   = 13;
  localparam int CNT_W    = 12;
  localparam int MAX_PEND = 4;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-3:0] base = '0;
  logic [CNT_W-1:0]  count = '0;
  logic [31:0]       seed = '0;
  logic              busy, done;
  logic [15:0]       err_count;
  logic [ADDR_W-1:0] first_fail_addr, avm_address;
  logic [3:0]        avm_byteenable;
  logic              avm_read, avm_write;
  logic [31:0]       avm_writedata;
  logic              avm_waitrequest = 1'b0;
  logic [31:0]       avm_readdata = '0;
  logic              avm_readdatavalid = 1'b0;

  always #5 clk = ~clk;

  onchip_mem_tester #(
    .ADDR_W   (ADDR_W),
    .CNT_W    (CNT_W),
    .MAX_PEND (MAX_PEND)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .start             (start),
    .base              (base),
    .count             (count),
    .seed              (seed),
    .busy              (busy),
    .done              (done),
    .err_count         (err_count),
    .first_fail_addr   (first_fail_addr),
    .avm_address       (avm_address),
    .avm_byteenable    (avm_byteenable),
    .avm_read          (avm_read),
    .avm_write         (avm_write),
    .avm_writedata     (avm_writedata),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid)
  );

  typedef struct { logic [12:0] addr; logic [31:0] data; } wr_t;
  typedef struct { logic [15:0] err;  logic [12:0] ffa;  } res_t;
  typedef struct { int due; logic [31:0] data; } rsp_t;

  wr_t         exp_wr[$];
  logic [12:0] exp_rd[$];
  res_t        exp_res[$];
  rsp_t        rsp_q[$];

  logic [31:0] mem [0:2047];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          rd_lat = 1;
  int          corrupt_word = -1;
  int          max_out = 0;
  int          bus_act = 0;
  int          last_rdv_edge = 0;
  bit          stall_req = 0, stall_ack = 0, stray_req = 0, stray_ack = 0;
  bit          stall_seen = 0;
  logic [12:0] stall_addr = '0;
  logic [31:0] stall_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event outside expected bounds", name);
  endtask

  // Slave model: memory plus in-order read responses with programmable latency.
  initial begin : slave
    bit          wr_acc, rd_acc;
    logic [12:0] a;
    logic [31:0] wd;
    int          cnt_stall;
    rsp_t        r;
    cnt_stall = 0;
    forever begin
      @(negedge clk);
      wr_acc = reset_n && avm_write && !avm_waitrequest;
      rd_acc = reset_n && avm_read && !avm_waitrequest;
      a      = avm_address;
      wd     = avm_writedata;
      if (avm_read || avm_write) bus_act++;
      @(posedge clk);
      cyc++;
      #1;
      if (!reset_n) begin
        rsp_q.delete();
        avm_readdatavalid = 1'b0;
        avm_readdata      = '0;
        avm_waitrequest   = 1'b0;
        cnt_stall         = 0;
      end else begin
        if (wr_acc) begin
          mem[a[12:2]] = wd;
          if (stall_req != stall_ack) begin
            stall_ack = stall_req;
            cnt_stall = 3;
          end
        end
        if (rd_acc) begin
          r.due  = cyc + rd_lat - 1;
          r.data = mem[a[12:2]] ^ ((int'(a[12:2]) == corrupt_word) ? 32'h1 : 32'h0);
          rsp_q.push_back(r);
        end
        if (rsp_q.size() > max_out) max_out = rsp_q.size();
        if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
          avm_readdatavalid = 1'b1;
          avm_readdata      = rsp_q[0].data;
          void'(rsp_q.pop_front());
          last_rdv_edge = cyc + 1;
        end else if (stray_req != stray_ack) begin
          stray_ack         = stray_req;
          avm_readdatavalid = 1'b1;
          avm_readdata      = 32'hDEAD_BEEF;
        end else begin
          avm_readdatavalid = 1'b0;
          avm_readdata      = '0;
        end
        avm_waitrequest = (cnt_stall > 0);
        if (cnt_stall > 0) cnt_stall--;
      end
    end
  end

  // Monitor: compares every accepted transfer and every done pulse with the queues.
  initial begin : monitor
    wr_t         e;
    res_t        rr;
    logic [12:0] ra, p_addr;
    logic [31:0] p_data;
    logic [1:0]  p_cmd;
    bit          prev_stall, last_wr_flag;
    prev_stall   = 0;
    last_wr_flag = 0;
    p_addr = '0; p_data = '0; p_cmd = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_stall   = 0;
        last_wr_flag = 0;
      end else begin
        if (avm_read && avm_write) fail_now("rd_wr_both");
        if (last_wr_flag) begin
          check("first_rd_after_wr", 32'(avm_read), 32'd1);
          last_wr_flag = 0;
        end
        if (avm_write && !avm_waitrequest) begin
          if (exp_wr.size() == 0) fail_now("wr_unexpected");
          else begin
            e = exp_wr.pop_front();
            check("wr_addr", 32'(avm_address), 32'(e.addr));
            check("wr_data", avm_writedata, e.data);
            check("wr_be", 32'(avm_byteenable), 32'hF);
            if (exp_wr.size() == 0) last_wr_flag = 1;
          end
        end
        if (avm_read && !avm_waitrequest) begin
          if (exp_rd.size() == 0) fail_now("rd_unexpected");
          else begin
            ra = exp_rd.pop_front();
            check("rd_addr", 32'(avm_address), 32'(ra));
            check("rd_be", 32'(avm_byteenable), 32'hF);
          end
        end
        if ((avm_read || avm_write) && avm_waitrequest) begin
          if (!stall_seen) begin
            stall_seen = 1;
            stall_addr = avm_address;
            stall_data = avm_writedata;
          end
          if (prev_stall) begin
            check("stall_addr_stable", 32'(avm_address), 32'(p_addr));
            check("stall_data_stable", avm_writedata, p_data);
            check("stall_cmd_stable", 32'({avm_read, avm_write}), 32'(p_cmd));
          end
          prev_stall = 1;
          p_addr = avm_address;
          p_data = avm_writedata;
          p_cmd  = {avm_read, avm_write};
        end else begin
          prev_stall = 0;
        end
        if (done) begin
          if (exp_res.size() == 0) fail_now("done_unexpected");
          else begin
            rr = exp_res.pop_front();
            check("err_count", 32'(err_count), 32'(rr.err));
            check("first_fail_addr", 32'(first_fail_addr), 32'(rr.ffa));
          end
        end
      end
    end
  end

  task automatic push_expect(input int b, input int c, input logic [31:0] s,
                             input logic [15:0] e_err, input logic [12:0] e_ffa);
    logic [12:0] a;
    for (int i = 0; i < c; i++) begin
      a = 13'(((b + i) % 2048) * 4);
      exp_wr.push_back('{addr: a, data: s + 32'(i)});
      exp_rd.push_back(a);
    end
    exp_res.push_back('{err: e_err, ffa: e_ffa});
  endtask

  // Start is sampled on edge N; returns at the negedge of the cycle after N.
  task automatic pulse_start(input int b, input int c, input logic [31:0] s);
    @(posedge clk);
    #1;
    base  = 11'(b);
    count = 12'(c);
    seed  = s;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic run(input string tag, input int b, input int c, input logic [31:0] s,
                     input logic [15:0] e_err, input logic [12:0] e_ffa);
    int n, act0;
    push_expect(b, c, s, e_err, e_ffa);
    act0 = bus_act;
    pulse_start(b, c, s);
    if (c == 0) begin
      check({tag, "_done_next_cycle"}, 32'(done), 32'd1);
      check({tag, "_busy_low"}, 32'(busy), 32'd0);
    end else begin
      check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
      check({tag, "_write_after_start"}, 32'(avm_write), 32'd1);
    end
    n = 0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      fail_now({tag, "_done_timeout"});
    end else begin
      check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
      if (c != 0) check({tag, "_done_after_last_rdv"}, 32'(cyc), 32'(last_rdv_edge));
      @(negedge clk);
      check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
      check({tag, "_err_hold"}, 32'(err_count), 32'(e_err));
    end
    check({tag, "_wr_left"}, 32'(exp_wr.size()), 32'd0);
    check({tag, "_rd_left"}, 32'(exp_rd.size()), 32'd0);
    check({tag, "_res_left"}, 32'(exp_res.size()), 32'd0);
    if (c == 0) check({tag, "_no_bus_activity"}, 32'(bus_act - act0), 32'd0);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int n;
    reset_n = 1'b0;
    #12;
    check("rst_ctrl", 32'({busy, done, avm_read, avm_write, avm_byteenable, err_count}), 32'd0);
    check("rst_addr", 32'({first_fail_addr, avm_address}), 32'd0);
    check("rst_wdata", avm_writedata, 32'd0);
    @(posedge clk);
    #3;
    reset_n = 1'b1;

    run("basic", 0, 4, 32'h0000_1000, 16'd0, 13'h0);

    rd_lat    = 8;
    stall_req = ~stall_req;
    run("stall", 0, 8, 32'h0000_1000, 16'd0, 13'h0);
    check("stall_seen", 32'(stall_seen), 32'd1);
    check("stall_hold_addr", 32'(stall_addr), 32'h4);
    check("stall_hold_data", stall_data, 32'h0000_1001);
    check("max_outstanding", 32'(max_out), 32'(MAX_PEND));
    rd_lat = 1;

    corrupt_word = 2;
    run("corrupt", 0, 4, 32'h0000_1000, 16'd1, 13'h8);
    corrupt_word = -1;

    run("empty", 0, 0, 32'h0000_0055, 16'd0, 13'h0);

    run("wrap", 2046, 4, 32'hA5A5_0000, 16'd0, 13'h0);

    // Reset during the read phase with two reads outstanding.
    rd_lat = 8;
    push_expect(0, 8, 32'h0000_2000, 16'd0, 13'h0);
    pulse_start(0, 8, 32'h0000_2000);
    n = 0;
    do begin
      @(posedge clk);
      #3;
      n++;
    end while (!(rsp_q.size() == 2 && avm_read) && n < 200);
    if (n >= 200) fail_now("midrst_reach_rd");
    reset_n = 1'b0;
    #1;
    check("midrst_ctrl", 32'({busy, done, avm_read, avm_write, avm_byteenable, err_count}), 32'd0);
    check("midrst_addr", 32'({first_fail_addr, avm_address}), 32'd0);
    check("midrst_wdata", avm_writedata, 32'd0);
    exp_wr.delete();
    exp_rd.delete();
    exp_res.delete();
    repeat (2) @(posedge clk);
    #3;
    reset_n   = 1'b1;
    stray_req = ~stray_req;
    repeat (4) @(negedge clk);
    check("stray_err_count", 32'(err_count), 32'd0);
    check("stray_first_fail", 32'(first_fail_addr), 32'd0);
    check("stray_busy", 32'(busy), 32'd0);
    rd_lat = 1;

    run("after_reset", 16, 6, 32'hFFFF_FFFE, 16'd0, 13'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/onchip_mem_tester.md
# onchip_mem_tester

Avalon-MM master that exercises a word-wide on-chip memory slave. On a start pulse it writes a deterministic pattern to a word range, then reads the range back with pipelined reads and compares each word. It reports an error count and the first failing address. It sits in the Qsys system beside the processor and is attached to the on-chip memory's second slave port for self-test.

## Interface
Parameters:
- ADDR_W, 13: master byte-address width; word space is 2^(ADDR_W-2) words (2048 at default).
- CNT_W, 12: width of the word-count input; must hold 2^(ADDR_W-2).
- MAX_PEND, 4: maximum outstanding reads (1..8).

Ports:
- clk  in  1  single clock for the block.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a run; ignored while busy.
- base  in  ADDR_W-2  first word index.
- count  in  CNT_W  number of words to test.
- seed  in  32  pattern seed.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at run end.
- err_count  out  16  mismatches in the last run; saturates at 16'hFFFF.
- first_fail_addr  out  ADDR_W  byte address of the first mismatch; 0 if none.
- avm_address  out  ADDR_W  byte address, always word aligned (bits [1:0]=0).
- avm_byteenable  out  4  always 4'hF while read or write is asserted.
- avm_read  out  1  read request.
- avm_write  out  1  write request.
- avm_writedata  out  32  write data.
- avm_waitrequest  in  1  slave stall.
- avm_readdata  in  32  read data.
- avm_readdatavalid  in  1  read response strobe; responses return in order.

## Operation
- Pattern: word i (0..count-1) = seed + i, modulo 2^32.
- Address: word index (base + i) mod 2^(ADDR_W-2); byte address = word index << 2. Addresses wrap silently.
- FSM states:
  - IDLE: on start, latch base/count/seed, clear err_count and first_fail_addr, set busy. Go to WR if count≠0, else DONE.
  - WR: issue writes i=0..count-1, then go to RD.
  - RD: issue reads while pending<MAX_PEND. After the last read is accepted, go to DRAIN.
  - DRAIN: wait until all responses are received, then go to DONE.
  - DONE: assert done and clear busy for one cycle, then return to IDLE.
- Handshake:
  - A transfer is accepted on a clk edge where (avm_read|avm_write) & !avm_waitrequest.
  - While stalled, address, writedata, read and write hold stable.
  - read and write are never asserted together.
- Pending counter:
  - +1 on read accept, −1 on readdatavalid.
  - Both in the same cycle leaves it unchanged.
  - readdatavalid with pending=0 is ignored.
- Compare:
  - The expected word comes from a receive index separate from the issue index.
  - On mismatch, err_count increments (saturating).
  - first_fail_addr is captured only on the first mismatch of the run.
- Results hold until the next accepted start.

## Timing
- Reset values: all outputs 0; FSM in IDLE; pending=0.
- Reset is asynchronous. Asserting it mid-run drops read/write immediately and abandons the run; responses arriving after release are ignored (pending=0).
- start sampled high at edge N: busy=1 and the first avm_write is asserted after edge N.
- With waitrequest=0, one write is accepted per cycle. The first read is asserted the cycle after the last write is accepted.
- With waitrequest=0, one read is issued per cycle until MAX_PEND reads are pending.
- Last readdatavalid sampled at edge K: done=1 and busy=0 in the cycle after K; err_count is final in that cycle.
- count=0: done pulses in the cycle after the start edge; no bus activity.

## Structure
- Package onchip_mem_tester_pkg:
  - FSM state enum (IDLE, WR, RD, DRAIN, DONE).
  - Pattern function seed+i.
  - Constant ERR_MAX=16'hFFFF.
- Sub-module onchip_mem_tester_chk contains:
  - the receive index;
  - the expected-value generator;
  - the comparator;
  - the saturating err_count and first_fail_addr capture.
  
  The top holds the FSM, the issue counter, the pending counter and the Avalon outputs.

## Test plan
- Basic run:
  - Stimulus: base=0, count=4, seed=32'h1000, waitrequest=0, slave read latency 1.
  - Response: writes of 32'h1000..32'h1003 to 0x0,0x4,0x8,0xC; then 4 reads; done with err_count=0, first_fail_addr=0.
- Stall and outstanding limit:
  - Stimulus: waitrequest held high 3 cycles on the 2nd write; slave read latency 8.
  - Response: address 0x4 and writedata 32'h1001 held stable with no duplicate write; pending never exceeds 4.
- Single corruption: slave flips bit 0 of word 2 on readback → err_count=1, first_fail_addr=0x8.
- Empty run: count=0 → done pulse in the cycle after start; avm_read and avm_write never asserted.
- Address wrap: base=2046, count=4 → addresses 0x1FF8, 0x1FFC, 0x0000, 0x0004 with no errors.
- Reset mid-run:
  - Stimulus: reset_n low during RD with 2 reads pending.
  - Response: all outputs 0 immediately; a stray readdatavalid after release leaves err_count at 0; the next run passes.
